branch_control_unit: RTL and testbench

- Control sequencer that drives the `Bus` datapath for instruction fetch and the jump/branch instruction subset.
- Replaces hand-sequenced testbench stimulus with an FSM that emits the one-hot register-select and strobe signals each cycle.
- Evaluates the branch condition (CON flip-flop) from the value on the bus.
- Sits directly upstream of the datapath: consumes `IR` and the bus, produces its control inputs.

---
 rtl/branch_control_unit.sv | 166 ++++++++++++++++
 tb/tb_branch_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// Control sequencer for the Bus datapath: instruction fetch plus the BR/JR/JAL/HALT subset.
// Strobes decode combinationally from the registered state and IR, and are gated off while clr is high.
module branch_control_unit #(
  parameter logic [4:0] OP_BR   = 5'b11100,
  parameter logic [4:0] OP_JR   = 5'b11101,
  parameter logic [4:0] OP_JAL  = 5'b11110,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic [31:0] BusData,
  input  logic        stop,
  output logic        PCout,
  output logic        PCins,
  output logic        incPC,
  output logic        MARins,
  output logic        MDRRead,
  output logic        MDRins,
  output logic        MDRout,
  output logic        IRins,
  output logic        Yins,
  output logic        Cout,
  output logic        ZLOins,
  output logic        ZLOout,
  output logic        ALUadd,
  output logic [15:0] Rout,
  output logic [15:0] Rins,
  output logic        CON,
  output logic        run
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t      state;
  logic [4:0]  op;
  logic [3:0]  ra;
  logic [1:0]  c2;
  logic        unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign c2        = IR[20:19];
  assign unused_ir = ^{IR[22:21], IR[18:0]};

  function automatic logic branch_cond(input logic [1:0] sel, input logic [31:0] bus);
    logic zero;
    zero = (bus == 32'd0);
    case (sel)
      2'b00:   branch_cond = zero;
      2'b01:   branch_cond = !zero;
      2'b10:   branch_cond = !bus[31] && !zero;
      default: branch_cond = bus[31];
    endcase
  endfunction

  function automatic state_t retire_to(input logic stop_req);
    retire_to = stop_req ? HALT : T0;
  endfunction

  function automatic logic [15:0] one_hot(input logic [3:0] idx);
    one_hot = 16'd1 << idx;
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= T0;
      CON   <= 1'b0;
    end else begin
      case (state)
        T0: state <= T1;
        T1: state <= T2;
        T2: state <= T3;
        T3: begin
          if (op == OP_BR) begin
            CON   <= branch_cond(c2, BusData);
            state <= T4;
          end else if (op == OP_JAL) begin
            state <= T4;
          end else if (op == OP_HALT) begin
            state <= HALT;
          end else begin
            state <= retire_to(stop);
          end
        end
        T4:      state <= (op == OP_BR) ? T5 : retire_to(stop);
        T5:      state <= T6;
        T6:      state <= retire_to(stop);
        HALT:    state <= HALT;
        default: state <= T0;
      endcase
    end
  end

  assign run = (state != HALT);

  // Strobe decode; clr masks everything, including the T0 fetch strobes.
  always_comb begin
    PCout   = 1'b0;
    PCins   = 1'b0;
    incPC   = 1'b0;
    MARins  = 1'b0;
    MDRRead = 1'b0;
    MDRins  = 1'b0;
    MDRout  = 1'b0;
    IRins   = 1'b0;
    Yins    = 1'b0;
    Cout    = 1'b0;
    ZLOins  = 1'b0;
    ZLOout  = 1'b0;
    ALUadd  = 1'b0;
    Rout    = 16'd0;
    Rins    = 16'd0;
    if (!clr) begin
      case (state)
        T0: begin
          PCout  = 1'b1;
          MARins = 1'b1;
          incPC  = 1'b1;
          ZLOins = 1'b1;
        end
        T1: begin
          ZLOout  = 1'b1;
          PCins   = 1'b1;
          MDRRead = 1'b1;
          MDRins  = 1'b1;
        end
        T2: begin
          MDRout = 1'b1;
          IRins  = 1'b1;
        end
        T3: begin
          if (op == OP_BR) begin
            Rout = one_hot(ra);
          end else if (op == OP_JR) begin
            Rout  = one_hot(ra);
            PCins = 1'b1;
          end else if (op == OP_JAL) begin
            PCout = 1'b1;
            Rins  = 16'h8000;
          end
        end
        T4: begin
          if (op == OP_BR) begin
            PCout = 1'b1;
            Yins  = 1'b1;
          end else if (op == OP_JAL) begin
            Rout  = one_hot(ra);
            PCins = 1'b1;
          end
        end
        T5: begin
          Cout   = 1'b1;
          ALUadd = 1'b1;
          ZLOins = 1'b1;
        end
        T6: begin
          ZLOout = 1'b1;
          PCins  = CON;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// Randomized bench for branch_control_unit against a per-instruction cycle-table model.
module tb_branch_control_unit;

  localparam logic [4:0] OP_BR   = 5'b11100;
  localparam logic [4:0] OP_JR   = 5'b11101;
  localparam logic [4:0] OP_JAL  = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [12:0] M_PCOUT   = 13'h1000;
  localparam logic [12:0] M_PCINS   = 13'h0800;
  localparam logic [12:0] M_INCPC   = 13'h0400;
  localparam logic [12:0] M_MARINS  = 13'h0200;
  localparam logic [12:0] M_MDRREAD = 13'h0100;
  localparam logic [12:0] M_MDRINS  = 13'h0080;
  localparam logic [12:0] M_MDROUT  = 13'h0040;
  localparam logic [12:0] M_IRINS   = 13'h0020;
  localparam logic [12:0] M_YINS    = 13'h0010;
  localparam logic [12:0] M_COUT    = 13'h0008;
  localparam logic [12:0] M_ZLOINS  = 13'h0004;
  localparam logic [12:0] M_ZLOOUT  = 13'h0002;
  localparam logic [12:0] M_ALUADD  = 13'h0001;

  logic        clk = 1'b0;
  logic        clr, stop;
  logic [31:0] IR, BusData;
  logic PCout, PCins, incPC, MARins, MDRRead, MDRins, MDRout, IRins;
  logic Yins, Cout, ZLOins, ZLOout, ALUadd, CON, run;
  logic [15:0] Rout, Rins;
  logic [44:0] obs;

  int   checks = 0;
  int   errors = 0;
  logic mcon   = 1'b0;

  branch_control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .BusData(BusData), .stop(stop),
    .PCout(PCout), .PCins(PCins), .incPC(incPC), .MARins(MARins),
    .MDRRead(MDRRead), .MDRins(MDRins), .MDRout(MDRout), .IRins(IRins),
    .Yins(Yins), .Cout(Cout), .ZLOins(ZLOins), .ZLOout(ZLOout),
    .ALUadd(ALUadd), .Rout(Rout), .Rins(Rins), .CON(CON), .run(run)
  );

  always #10 clk = ~clk;

  assign obs = {PCout, PCins, incPC, MARins, MDRRead, MDRins, MDRout, IRins,
                Yins, Cout, ZLOins, ZLOout, ALUadd, Rout, Rins};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra, input logic [1:0] c2);
    return (32'(op) << 27) | (32'(ra) << 23) | (32'(c2) << 19);
  endfunction

  function automatic int latency(input logic [4:0] op);
    if (op == OP_BR)  return 7;
    if (op == OP_JAL) return 5;
    return 4;
  endfunction

  function automatic logic model_cond(input logic [1:0] c2, input logic [31:0] b);
    case (c2)
      2'd0:    return b == 0;
      2'd1:    return b != 0;
      2'd2:    return $signed(b) > 0;
      default: return $signed(b) < 0;
    endcase
  endfunction

  function automatic logic [44:0] exp_vec(input int c, input logic [4:0] op,
                                          input logic [3:0] ra, input logic con);
    logic [12:0] s;
    logic [15:0] ro, ri;
    s = '0; ro = '0; ri = '0;
    if (c == 0)      s = M_PCOUT | M_MARINS | M_INCPC | M_ZLOINS;
    else if (c == 1) s = M_ZLOOUT | M_PCINS | M_MDRREAD | M_MDRINS;
    else if (c == 2) s = M_MDROUT | M_IRINS;
    else if (op == OP_BR) begin
      if (c == 3) ro = 16'(1) << ra;
      if (c == 4) s = M_PCOUT | M_YINS;
      if (c == 5) s = M_COUT | M_ALUADD | M_ZLOINS;
      if (c == 6) s = M_ZLOOUT | (con ? M_PCINS : 13'h0);
    end else if (op == OP_JR) begin
      if (c == 3) begin ro = 16'(1) << ra; s = M_PCINS; end
    end else if (op == OP_JAL) begin
      if (c == 3) begin s = M_PCOUT; ri = 16'h8000; end
      if (c == 4) begin s = M_PCINS; ro = 16'(1) << ra; end
    end
    return {s, ro, ri};
  endfunction

  // Entered #1 after a rising edge; leaves the DUT in T0 at the same phase.
  task automatic do_reset();
    clr = 1'b1;
    #1;
    check_eq("rst_vec", 64'(obs), 64'd0);
    check_eq("rst_run", 64'(run), 64'd1);
    check_eq("rst_con", 64'(CON), 64'd0);
    mcon = 1'b0;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic [31:0] bus3, input logic stp,
                           input int start_c, input int abort_at, input int halt_cycles);
    logic [4:0] op;
    logic [3:0] ra;
    int n;
    op = ir[31:27];
    ra = ir[26:23];
    IR = ir;
    stop = stp;
    n = latency(op);
    for (int c = start_c; c < n; c++) begin
      BusData = (c == 3) ? bus3 : $urandom;
      @(negedge clk);
      check_eq($sformatf("vec_op%0h_c%0d", op, c), 64'(obs), 64'(exp_vec(c, op, ra, mcon)));
      check_eq($sformatf("con_op%0h_c%0d", op, c), 64'(CON), 64'(mcon));
      check_eq($sformatf("run_op%0h_c%0d", op, c), 64'(run), 64'd1);
      if (c == abort_at) begin
        #1 clr = 1'b1;
        #1;
        check_eq("abort_vec", 64'(obs), 64'd0);
        check_eq("abort_con", 64'(CON), 64'd0);
        check_eq("abort_run", 64'(run), 64'd1);
        #2 clr = 1'b0;
        mcon = 1'b0;
        #1;
        check_eq("abort_t0", 64'(obs), 64'(exp_vec(0, op, ra, 1'b0)));
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (c == 3 && op == OP_BR) mcon = model_cond(ir[20:19], bus3);
    end
    if (stp || op == OP_HALT) begin
      for (int k = 0; k < halt_cycles; k++) begin
        stop = 1'($urandom);
        BusData = $urandom;
        @(negedge clk);
        check_eq("halt_run", 64'(run), 64'd0);
        check_eq("halt_vec", 64'(obs), 64'd0);
        check_eq("halt_con", 64'(CON), 64'(mcon));
        @(posedge clk);
        #1;
      end
      stop = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] bus;
    clr = 1'b1;
    stop = 1'b0;
    IR = 32'h0;
    BusData = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(32'hE800_0000, 32'h0, 1'b0, 0, -1, 0);
    run_instr(32'hE000_0000, 32'h0, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd2, 2'b10), 32'h0000_0022, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd2, 2'b10), 32'h8000_0000, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd2, 2'b10), 32'h0000_0000, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd5, 2'b11), 32'hFFFF_FFFF, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd7, 2'b01), 32'h0000_0000, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_JR, 4'd9, 2'b00), 32'h0, 1'b0, 0, -1, 0);
    run_instr(32'hF180_0000, 32'h0, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_JAL, 4'd15, 2'b00), 32'h0, 1'b0, 0, -1, 0);
    run_instr(mk_ir(5'b00011, 4'd4, 2'b00), 32'h0, 1'b0, 0, -1, 0);
    run_instr(32'hD800_0000, 32'h0, 1'b0, 0, -1, 20);
    run_instr(32'hE800_0000, 32'h0, 1'b1, 0, -1, 3);

    run_instr(32'hE000_0000, 32'h0, 1'b0, 0, -1, 0);
    run_instr(mk_ir(OP_BR, 4'd1, 2'b00), 32'h0, 1'b0, 0, 5, 0);
    run_instr(mk_ir(OP_JR, 4'd1, 2'b00), 32'h0, 1'b0, 1, -1, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_BR;
        1: op = OP_JR;
        2: op = OP_JAL;
        default: begin
          op = 5'($urandom);
          while (op == OP_BR || op == OP_JR || op == OP_JAL || op == OP_HALT) op = 5'($urandom);
        end
      endcase
      case ($urandom_range(0, 3))
        0: bus = 32'h0;
        1: bus = 32'h8000_0000;
        2: bus = 32'($urandom_range(1, 255));
        default: bus = $urandom;
      endcase
      run_instr(mk_ir(op, 4'($urandom), 2'($urandom)), bus,
                ($urandom_range(0, 9) == 0), 0, -1, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
